// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product after WIDTH cycles.
// No backpressure: start is honoured only in IDLE/DONE, and the result is held in DONE until the next launch.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mulIn1,
  input  logic [WIDTH-1:0]   mulIn2,
  output logic [2*WIDTH-1:0] mulOut,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_acc;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_mul_out;
  logic                 r_overflow;

  logic [1:0]           w_next_state;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic                 w_last;

  // w_sum is WIDTH+1 bits so the adder carry shifts into the accumulator MSB.
  always_comb begin
    w_addend = r_b[0] ? r_a : '0;
    w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
    w_last   = (r_count == CW'(WIDTH - 1));
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = S_CALC;
      S_CALC:         if (w_last) w_next_state = S_DONE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_mul_out  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= mulIn1;
            r_b     <= mulIn2;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        S_CALC: begin
          // The multiplier register doubles as the low half of the product.
          r_acc   <= w_sum[WIDTH:1];
          r_b     <= {w_sum[0], r_b[WIDTH-1:1]};
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_mul_out  <= {w_sum[WIDTH:1], w_sum[0], r_b[WIDTH-1:1]};
            r_overflow <= |w_sum[WIDTH:1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == S_CALC);
  assign done     = (r_state == S_DONE);
  assign mulOut   = r_mul_out;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (WIDTH=8): expected products queued at launch, popped at done.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   mulIn1;
  logic [W-1:0]   mulIn2;
  logic [2*W-1:0] mulOut;
  logic           overflow;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clock = ~clock;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .mulIn1(mulIn1), .mulIn2(mulIn2),
    .mulOut(mulOut), .overflow(overflow), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    mulIn1 = a;
    mulIn2 = b;
    start  = 1'b1;
    exp_q.push_back({8'd0, a} * {8'd0, b});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mulIn1 = '0; mulIn2 = '0;
    #12;
    n_checks++; if (mulOut !== 16'd0) begin n_errors++; $display("FAIL reset_mulOut got %h want 0000", mulOut); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [2*W-1:0] e;
    launch(8'd13, 8'd11);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_start got %b want 1", busy); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++; if (done !== (i == 8)) begin n_errors++; $display("FAIL basic_done edge %0d got %b want %b", i, done, i == 8); end
      n_checks++; if (busy !== (i != 8)) begin n_errors++; $display("FAIL basic_busy edge %0d got %b want %b", i, busy, i != 8); end
    end
    e = exp_q.pop_front();
    n_checks++; if (mulOut !== e) begin n_errors++; $display("FAIL basic_product got %0d want %0d", mulOut, e); end
    n_checks++; if (overflow !== (e[15:8] != 0)) begin n_errors++; $display("FAIL basic_overflow got %b want %b", overflow, e[15:8] != 0); end
  endtask

  task automatic test_protocol();
    logic [2*W-1:0] e;
    launch(8'd13, 8'd11);
    for (int i = 1; i <= 8; i++) begin
      mulIn1 = 8'($urandom);
      mulIn2 = 8'($urandom);
      start  = 1'($urandom);
      tick();
      n_checks++; if (done !== (i == 8)) begin n_errors++; $display("FAIL proto_done edge %0d got %b want %b", i, done, i == 8); end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (mulOut !== e) begin n_errors++; $display("FAIL proto_product got %0d want %0d", mulOut, e); end
    mulIn1 = 'x;
    mulIn2 = 'x;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++; if (done !== 1'b1 || mulOut !== e) begin n_errors++; $display("FAIL proto_hold cycle %0d got done=%b out=%0d want done=1 out=%0d", i, done, mulOut, e); end
    end
  endtask

  task automatic test_relaunch();
    logic [2*W-1:0] e;
    launch(8'd7, 8'd9);
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL relaunch_edge got done=%b busy=%b want done=0 busy=1", done, busy); end
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (mulOut !== 16'd143) begin n_errors++; $display("FAIL relaunch_old edge %0d got %0d want 143", i - 1, mulOut); end
      tick();
    end
    e = exp_q.pop_front();
    n_checks++; if (done !== 1'b1 || mulOut !== e) begin n_errors++; $display("FAIL relaunch_new got done=%b out=%0d want done=1 out=%0d", done, mulOut, e); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 4;
    logic [2*W-1:0] e;
    logic [W-1:0] a, b;
    a = 8'($urandom_range(1, 255));
    b = 8'($urandom_range(1, 255));
    mulIn1 = a; mulIn2 = b; start = 1'b1;
    exp_q.push_back({8'd0, a} * {8'd0, b});
    tick();
    for (int r = 0; r < N; r++) begin
      if (r < N - 1) begin
        a = 8'($urandom_range(1, 255));
        b = 8'($urandom_range(1, 255));
        mulIn1 = a; mulIn2 = b;
        exp_q.push_back({8'd0, a} * {8'd0, b});
      end else begin
        start = 1'b0;
      end
      for (int i = 1; i <= 8; i++) begin
        tick();
        n_checks++; if (done !== (i == 8)) begin n_errors++; $display("FAIL b2b_done res %0d edge %0d got %b want %b", r, i, done, i == 8); end
      end
      e = exp_q.pop_front();
      n_checks++; if (mulOut !== e) begin n_errors++; $display("FAIL b2b_product res %0d got %0d want %0d", r, mulOut, e); end
      n_checks++; if (overflow !== (e[15:8] != 0)) begin n_errors++; $display("FAIL b2b_overflow res %0d got %b want %b", r, overflow, e[15:8] != 0); end
      if (r < N - 1) begin
        tick();
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL b2b_relaunch res %0d got busy=%b done=%b want busy=1 done=0", r, busy, done); end
      end
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0]   ta[4] = '{8'd255, 8'd0,   8'd1,   8'd16};
    logic [W-1:0]   tb[4] = '{8'd255, 8'd200, 8'd255, 8'd16};
    logic [2*W-1:0] tp[4] = '{16'hFE01, 16'd0, 16'd255, 16'd256};
    logic           to[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2*W-1:0] e;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i]);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++; if (cyc !== 8) begin n_errors++; $display("FAIL ext_latency %0d*%0d got %0d want 8", ta[i], tb[i], cyc); end
      n_checks++; if (mulOut !== tp[i]) begin n_errors++; $display("FAIL ext_product %0d*%0d got %0d want %0d", ta[i], tb[i], mulOut, tp[i]); end
      n_checks++; if (mulOut !== e) begin n_errors++; $display("FAIL ext_scoreboard %0d*%0d got %0d want %0d", ta[i], tb[i], mulOut, e); end
      n_checks++; if (overflow !== to[i]) begin n_errors++; $display("FAIL ext_overflow %0d*%0d got %b want %b", ta[i], tb[i], overflow, to[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] e;
    int cyc;
    launch(8'd200, 8'd200);
    for (int i = 0; i < 3; i++) tick();
    #2;
    reset = 1'b0;
    e = exp_q.pop_back();
    #1;
    n_checks++; if (mulOut !== 16'd0 || overflow !== 1'b0) begin n_errors++; $display("FAIL rstmid_outputs got out=%0d ovf=%b want 0/0", mulOut, overflow); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL rstmid_flags got busy=%b done=%b want 0/0", busy, done); end
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || mulOut !== 16'd0) begin n_errors++; $display("FAIL rstmid_idle got busy=%b done=%b out=%0d want 0/0/0", busy, done, mulOut); end
    launch(8'd100, 8'd3);
    wait_done(cyc);
    e = exp_q.pop_front();
    n_checks++; if (cyc !== 8) begin n_errors++; $display("FAIL rstmid_latency got %0d want 8", cyc); end
    n_checks++; if (mulOut !== e || e !== 16'd300) begin n_errors++; $display("FAIL rstmid_product got %0d want 300", mulOut); end
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL rstmid_overflow got %b want 1", overflow); end
  endtask

  task automatic test_random();
    logic [2*W-1:0] e;
    logic [W-1:0] a, b;
    int cyc;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      launch(a, b);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++; if (cyc !== 8) begin n_errors++; $display("FAIL rand_latency %0d*%0d got %0d want 8", a, b, cyc); end
      n_checks++; if (mulOut !== e) begin n_errors++; $display("FAIL rand_product %0d*%0d got %0d want %0d", a, b, mulOut, e); end
      n_checks++; if (overflow !== (e > 16'd255)) begin n_errors++; $display("FAIL rand_overflow %0d*%0d got %b want %b", a, b, overflow, e > 16'd255); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_protocol();
    test_relaunch();
    test_back_to_back();
    test_extremes();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Iterative unsigned shift-and-add integer multiplier. It is the inverse-operation companion to the FPU restoring divider.
- It uses the same start/done handshake, so FPU control and mantissa datapaths can drive either unit the same way.
- It takes two WIDTH-bit operands and produces a full 2*WIDTH-bit product after a fixed WIDTH-cycle iteration.
- It computes one partial product per clock, so no wide combinational multiplier is needed.

Parameters:
- WIDTH, 8, operand width in bits. Legal values are 2..32. The product width is 2*WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) immediately clears all state; deassertion is synchronous to clock.
- start  input  1  launches a multiply when sampled high in IDLE or DONE.
- mulIn1  input  WIDTH  multiplicand, unsigned; captured on the start edge.
- mulIn2  input  WIDTH  multiplier, unsigned; captured on the start edge.
- mulOut  output  2*WIDTH  product; valid while done=1.
- overflow  output  1  upper WIDTH bits of the product are nonzero; valid while done=1.
- busy  output  1  high while iterating (CALC).
- done  output  1  high in DONE; held until the next launch.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mulOut=0, overflow=0, busy=0, done=0; internal operand, accumulator and counter registers all cleared.
- States: IDLE, CALC, DONE; 2-bit encoding, registered next-state logic.
- IDLE:
  - start=1 at a rising edge (edge k): capture A=mulIn1 and B=mulIn2; acc=0, count=0.
  - Next state CALC; busy=1 from edge k.
- CALC, one iteration per edge (k+1 .. k+WIDTH):
  - If B[0]=1, add A into the upper WIDTH+1 bits of acc.
  - Shift {carry, acc, B} right by one; count increments.
- Last iteration (count==WIDTH-1, edge k+WIDTH):
  - mulOut=final product, overflow=|mulOut[2*WIDTH-1:WIDTH].
  - busy=0, done=1, next state DONE.
  - done is therefore first visible in the cycle after edge k+WIDTH (8 cycles after start for WIDTH=8).
- Latency is fixed and independent of operand values; zero operands do not take an early exit.
- start while in CALC: ignored. Operands and iteration are unaffected, and operand input changes in CALC have no effect.
- DONE: done=1 and mulOut/overflow are held stable indefinitely.
  - start=1 at an edge: relaunch exactly as from IDLE.
  - done drops to 0 and busy rises at that same edge.
  - mulOut keeps the old value until the new result is written at the final CALC edge.
- start held high continuously: back-to-back multiplies, one every WIDTH+1 edges.
- Reset mid-CALC: the operation is aborted and all outputs are zeroed immediately. No partial result is ever presented.
- Arithmetic: unsigned only; the product is exact (no truncation). The maximum value, (2^WIDTH-1)^2, fits in 2*WIDTH bits.
- The adder carry out must be kept in the shift so the MSB is not lost.
- No X may propagate to outputs after reset, even if inputs are X while not in a start cycle.

Test Plan (WIDTH=8):
- Basic: mulIn1=13, mulIn2=11, one-cycle start.
  - Required: busy for 8 cycles, then done=1, mulOut=143, overflow=0.
  - done must be 0 on every cycle before the 8th post-start edge.
- Extremes and overflow: 255*255 -> mulOut=65025 (0xFE01), overflow=1. 0*200 -> 0, overflow=0. 1*255 -> 255, overflow=0. 16*16 -> 256, overflow=1.
- Protocol:
  - Change mulIn1/mulIn2 and pulse start during CALC; the result must still be 13*11=143 with the original latency.
  - Then hold DONE for 20 cycles; done and mulOut must stay stable.
- Relaunch from DONE: start with 7*9 while done=1.
  - done falls at that edge and mulOut stays 143 until it becomes 63 eight edges later.
  - start held high gives back-to-back results every 9 edges.
- Reset mid-operation: assert reset=0 between clock edges during CALC cycle 4.
  - Outputs go to 0 immediately, before the next edge.
  - After release, a new 100*3 returns 300 with overflow=1.
- Random: 1000 random operand pairs; compare mulOut against the exact mulIn1*mulIn2 and overflow against (product>255).
